roic_pixel_capture: RTL

//  Receiving end of the ROIC row/column scan. Watches the one-hot row/column enables driven
//  by the traversal sequencer, samples pixel ADC data once per addressed pixel after a settle

---
 rtl/roic_pkg.sv | 27 ++
 rtl/roic_frame_bank.sv | 29 ++
 rtl/roic_pixel_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/roic_pkg.sv
// Shared definitions for the ROIC pixel capture slice: default array
// geometry, capture FSM encoding and the one-hot to index decoder.
package roic_pkg;

    localparam int DEF_NCOL  = 9;
    localparam int DEF_NROW  = 2;
    localparam int FRAME_PIX = DEF_NROW * DEF_NCOL;
    localparam int IDX_W     = $clog2(FRAME_PIX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } cap_state_t;

    // OR of the positions of all set bits; exact for a one-hot input.
    function automatic logic [7:0] onehot_idx(input logic [31:0] vec);
        logic [7:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = idx | 8'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/roic_frame_bank.sv
// Ping-pong frame storage: two banks of DEPTH pixels. Writes go to the
// capture bank, reads come from the other (readout) bank. Storage is data
// only and carries no reset.
module roic_frame_bank
    import roic_pkg::*;
#(
    parameter int DW    = 12,
    parameter int DEPTH = FRAME_PIX,
    parameter int AW    = IDX_W
) (
    input  logic          clk,
    input  logic          cap_bank,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2][DEPTH];

    // Single write port into the bank currently being captured.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cap_bank][wr_addr] <= wr_data;
    end

    assign rd_data = mem[~cap_bank][rd_addr];

endmodule

// File: rtl/roic_pixel_capture.sv
// Receiving end of the ROIC row/column scan: decodes the one-hot enables,
// samples each addressed pixel after a settle delay, checks scan order and
// streams completed frames out of a ping-pong buffer over valid/ready.
module roic_pixel_capture
    import roic_pkg::*;
#(
    parameter int NCOL   = DEF_NCOL,
    parameter int NROW   = DEF_NROW,
    parameter int DW     = 12,
    parameter int SETTLE = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NCOL-1:0]              col_enable,
    input  logic [NROW-1:0]              row_enable,
    input  logic [DW-1:0]                pix_data,
    output logic [DW-1:0]                out_data,
    output logic [$clog2(NROW*NCOL)-1:0] out_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         frame_done,
    output logic                         overflow,
    output logic                         proto_err
);

    localparam int PIX = NROW * NCOL;
    localparam int AW  = $clog2(PIX);
    localparam int CW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(PIX - 1);

    logic [NCOL-1:0] col_en_p0;
    logic [NROW-1:0] row_en_p0;
    logic [DW-1:0]   pix_p0;

    logic            pat_valid, pat_idle, pat_bad, pat_same;
    logic [AW-1:0]   pat_idx;

    cap_state_t      state, state_nxt;
    logic            load;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   lat_idx, exp_idx;
    logic            sample_we, frame_end;

    logic            cap_bank, rd_full;
    logic [AW-1:0]   rd_idx;
    logic [DW-1:0]   rd_data;
    logic            hs, rd_empty_eff;

    // Stage p0: register enables (control, reset) and pixel data (no reset).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_en_p0 <= '0;
            row_en_p0 <= '0;
        end else begin
            col_en_p0 <= col_enable;
            row_en_p0 <= row_enable;
        end
    end

    // Pixel sample travels with the enables so SAMPLE writes the p0 value.
    always_ff @(posedge clk) begin
        pix_p0 <= pix_data;
    end

    assign pat_valid = $onehot(row_en_p0) && $onehot(col_en_p0);
    assign pat_idle  = (row_en_p0 == '0) && (col_en_p0 == '0);
    assign pat_bad   = !pat_valid && !pat_idle;
    assign pat_idx   = AW'(onehot_idx(32'(row_en_p0))) * AW'(NCOL)
                     + AW'(onehot_idx(32'(col_en_p0)));
    assign pat_same  = pat_valid && (pat_idx == lat_idx);

    // Capture FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state; a changed pattern always wins over the settle countdown.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pat_valid) begin
                    state_nxt = ST_SETTLE;
                    load      = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!pat_same) begin
                    load      = pat_valid;
                    state_nxt = pat_valid ? ST_SETTLE : ST_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (!pat_same) begin
                    load      = pat_valid;
                    state_nxt = pat_valid ? ST_SETTLE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: bank write strobe and end-of-frame detect.
    always_comb begin
        sample_we = (state == ST_SAMPLE);
        frame_end = sample_we && (lat_idx == LAST_IDX);
    end

    // Settle counter, latched pixel index, scan-order tracking, protocol flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_idx   <= '0;
            exp_idx   <= '0;
            proto_err <= 1'b0;
        end else begin
            if (load) begin
                cnt     <= CW'(SETTLE - 1);
                lat_idx <= pat_idx;
            end else if (state == ST_SETTLE && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (sample_we) begin
                exp_idx <= (lat_idx == LAST_IDX) ? '0 : lat_idx + 1'b1;
            end
            if (pat_bad || (sample_we && lat_idx != exp_idx)) proto_err <= 1'b1;
        end
    end

    assign hs           = rd_full && out_ready;
    assign rd_empty_eff = !rd_full || (hs && rd_idx == LAST_IDX);

    // Readout sequencing and bank swap; a swap may coincide with the last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_full    <= 1'b0;
            rd_idx     <= '0;
            cap_bank   <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (hs) begin
                if (rd_idx == LAST_IDX) begin
                    rd_full <= 1'b0;
                    rd_idx  <= '0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
            if (frame_end) begin
                if (rd_empty_eff) begin
                    rd_full    <= 1'b1;
                    rd_idx     <= '0;
                    cap_bank   <= ~cap_bank;
                    frame_done <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    roic_frame_bank #(
        .DW    (DW),
        .DEPTH (PIX),
        .AW    (AW)
    ) u_bank (
        .clk      (clk),
        .cap_bank (cap_bank),
        .wr_en    (sample_we),
        .wr_addr  (lat_idx),
        .wr_data  (pix_p0),
        .rd_addr  (rd_idx),
        .rd_data  (rd_data)
    );

    assign out_valid = rd_full;
    assign out_addr  = rd_idx;
    assign out_last  = rd_full && (rd_idx == LAST_IDX);
    assign out_data  = rd_full ? rd_data : '0;

endmodule
